// File: rtl/axi_sram_arbiter.sv
// rtl/axi_sram_arbiter.sv - 2:1 AXI4 read/write arbiter in front of the SRAM slave (optional AXI_ARB_QOS_EN)
module axi_sram_arbiter #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 31,
  parameter int DATA_W = 64
) (
  input  logic                axi4_aclk,
  input  logic                axi4_aresetn,
  // master 0
  input  logic [ID_W-1:0]     axi4_s0_awid,
  input  logic [ADDR_W-1:0]   axi4_s0_awaddr,
  input  logic [7:0]          axi4_s0_awlen,
  input  logic [2:0]          axi4_s0_awsize,
  input  logic [1:0]          axi4_s0_awburst,
  input  logic [3:0]          axi4_s0_awqos,
  input  logic                axi4_s0_awvalid,
  output logic                axi4_s0_awready,
  input  logic [DATA_W-1:0]   axi4_s0_wdata,
  input  logic [DATA_W/8-1:0] axi4_s0_wstrb,
  input  logic                axi4_s0_wlast,
  input  logic                axi4_s0_wvalid,
  output logic                axi4_s0_wready,
  output logic [ID_W-1:0]     axi4_s0_bid,
  output logic [1:0]          axi4_s0_bresp,
  output logic                axi4_s0_bvalid,
  input  logic                axi4_s0_bready,
  input  logic [ID_W-1:0]     axi4_s0_arid,
  input  logic [ADDR_W-1:0]   axi4_s0_araddr,
  input  logic [7:0]          axi4_s0_arlen,
  input  logic [2:0]          axi4_s0_arsize,
  input  logic [1:0]          axi4_s0_arburst,
  input  logic [3:0]          axi4_s0_arqos,
  input  logic                axi4_s0_arvalid,
  output logic                axi4_s0_arready,
  output logic [ID_W-1:0]     axi4_s0_rid,
  output logic [DATA_W-1:0]   axi4_s0_rdata,
  output logic [1:0]          axi4_s0_rresp,
  output logic                axi4_s0_rlast,
  output logic                axi4_s0_rvalid,
  input  logic                axi4_s0_rready,
  // master 1
  input  logic [ID_W-1:0]     axi4_s1_awid,
  input  logic [ADDR_W-1:0]   axi4_s1_awaddr,
  input  logic [7:0]          axi4_s1_awlen,
  input  logic [2:0]          axi4_s1_awsize,
  input  logic [1:0]          axi4_s1_awburst,
  input  logic [3:0]          axi4_s1_awqos,
  input  logic                axi4_s1_awvalid,
  output logic                axi4_s1_awready,
  input  logic [DATA_W-1:0]   axi4_s1_wdata,
  input  logic [DATA_W/8-1:0] axi4_s1_wstrb,
  input  logic                axi4_s1_wlast,
  input  logic                axi4_s1_wvalid,
  output logic                axi4_s1_wready,
  output logic [ID_W-1:0]     axi4_s1_bid,
  output logic [1:0]          axi4_s1_bresp,
  output logic                axi4_s1_bvalid,
  input  logic                axi4_s1_bready,
  input  logic [ID_W-1:0]     axi4_s1_arid,
  input  logic [ADDR_W-1:0]   axi4_s1_araddr,
  input  logic [7:0]          axi4_s1_arlen,
  input  logic [2:0]          axi4_s1_arsize,
  input  logic [1:0]          axi4_s1_arburst,
  input  logic [3:0]          axi4_s1_arqos,
  input  logic                axi4_s1_arvalid,
  output logic                axi4_s1_arready,
  output logic [ID_W-1:0]     axi4_s1_rid,
  output logic [DATA_W-1:0]   axi4_s1_rdata,
  output logic [1:0]          axi4_s1_rresp,
  output logic                axi4_s1_rlast,
  output logic                axi4_s1_rvalid,
  input  logic                axi4_s1_rready,
  // SRAM slave side
  output logic [ID_W-1:0]     axi4_mst_awid,
  output logic [ADDR_W-1:0]   axi4_mst_awaddr,
  output logic [7:0]          axi4_mst_awlen,
  output logic [2:0]          axi4_mst_awsize,
  output logic [1:0]          axi4_mst_awburst,
  output logic [3:0]          axi4_mst_awqos,
  output logic                axi4_mst_awvalid,
  input  logic                axi4_mst_awready,
  output logic [DATA_W-1:0]   axi4_mst_wdata,
  output logic [DATA_W/8-1:0] axi4_mst_wstrb,
  output logic                axi4_mst_wlast,
  output logic                axi4_mst_wvalid,
  input  logic                axi4_mst_wready,
  input  logic [ID_W-1:0]     axi4_mst_bid,
  input  logic [1:0]          axi4_mst_bresp,
  input  logic                axi4_mst_bvalid,
  output logic                axi4_mst_bready,
  output logic [ID_W-1:0]     axi4_mst_arid,
  output logic [ADDR_W-1:0]   axi4_mst_araddr,
  output logic [7:0]          axi4_mst_arlen,
  output logic [2:0]          axi4_mst_arsize,
  output logic [1:0]          axi4_mst_arburst,
  output logic [3:0]          axi4_mst_arqos,
  output logic                axi4_mst_arvalid,
  input  logic                axi4_mst_arready,
  input  logic [ID_W-1:0]     axi4_mst_rid,
  input  logic [DATA_W-1:0]   axi4_mst_rdata,
  input  logic [1:0]          axi4_mst_rresp,
  input  logic                axi4_mst_rlast,
  input  logic                axi4_mst_rvalid,
  output logic                axi4_mst_rready
);

  typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;

  wr_state_t wr_state, wr_state_n;
  rd_state_t rd_state, rd_state_n;
  logic      wr_gnt, wr_gnt_n, wr_ptr, wr_ptr_n;
  logic      aw_done, aw_done_n, w_done, w_done_n;
  logic      rd_gnt, rd_gnt_n, rd_ptr, rd_ptr_n;
  logic      wr_pick, rd_pick;
  logic      wr_xfer, wr_resp, rd_addr, rd_data;

  assign wr_xfer = (wr_state == W_XFER);
  assign wr_resp = (wr_state == W_RESP);
  assign rd_addr = (rd_state == R_ADDR);
  assign rd_data = (rd_state == R_DATA);

  // Winner for the next grant: lone requester wins, contention goes to the master that did not win last
  always_comb begin
    wr_pick = axi4_s1_awvalid & ~axi4_s0_awvalid;
    rd_pick = axi4_s1_arvalid & ~axi4_s0_arvalid;
    if (axi4_s0_awvalid && axi4_s1_awvalid) begin
      wr_pick = ~wr_ptr;
`ifdef AXI_ARB_QOS_EN
      if (axi4_s0_awqos != axi4_s1_awqos) wr_pick = (axi4_s1_awqos > axi4_s0_awqos);
`endif
    end
    if (axi4_s0_arvalid && axi4_s1_arvalid) begin
      rd_pick = ~rd_ptr;
`ifdef AXI_ARB_QOS_EN
      if (axi4_s0_arqos != axi4_s1_arqos) rd_pick = (axi4_s1_arqos > axi4_s0_arqos);
`endif
    end
  end

`ifndef AXI_ARB_QOS_EN
  logic unused_qos;
  assign unused_qos = ^{axi4_s0_awqos, axi4_s1_awqos, axi4_s0_arqos, axi4_s1_arqos};
`endif

  // Write FSM next state: AW and W progress independently inside W_XFER
  always_comb begin
    wr_state_n = wr_state;
    wr_gnt_n   = wr_gnt;
    wr_ptr_n   = wr_ptr;
    aw_done_n  = aw_done;
    w_done_n   = w_done;
    case (wr_state)
      W_IDLE: begin
        if (axi4_s0_awvalid || axi4_s1_awvalid) begin
          wr_gnt_n   = wr_pick;
          wr_ptr_n   = wr_pick;
          aw_done_n  = 1'b0;
          w_done_n   = 1'b0;
          wr_state_n = W_XFER;
        end
      end
      W_XFER: begin
        if (axi4_mst_awvalid && axi4_mst_awready) aw_done_n = 1'b1;
        if (axi4_mst_wvalid && axi4_mst_wready && axi4_mst_wlast) w_done_n = 1'b1;
        if (aw_done_n && w_done_n) wr_state_n = W_RESP;
      end
      W_RESP: begin
        if (axi4_mst_bvalid && axi4_mst_bready) wr_state_n = W_IDLE;
      end
      default: wr_state_n = W_IDLE;
    endcase
  end

  // Read FSM next state
  always_comb begin
    rd_state_n = rd_state;
    rd_gnt_n   = rd_gnt;
    rd_ptr_n   = rd_ptr;
    case (rd_state)
      R_IDLE: begin
        if (axi4_s0_arvalid || axi4_s1_arvalid) begin
          rd_gnt_n   = rd_pick;
          rd_ptr_n   = rd_pick;
          rd_state_n = R_ADDR;
        end
      end
      R_ADDR: begin
        if (axi4_mst_arvalid && axi4_mst_arready) rd_state_n = R_DATA;
      end
      R_DATA: begin
        if (axi4_mst_rvalid && axi4_mst_rready && axi4_mst_rlast) rd_state_n = R_IDLE;
      end
      default: rd_state_n = R_IDLE;
    endcase
  end

  // State, grant and round-robin pointer registers
  always_ff @(posedge axi4_aclk) begin
    if (!axi4_aresetn) begin
      wr_state <= W_IDLE;
      wr_gnt   <= 1'b0;
      wr_ptr   <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      rd_state <= R_IDLE;
      rd_gnt   <= 1'b0;
      rd_ptr   <= 1'b0;
    end else begin
      wr_state <= wr_state_n;
      wr_gnt   <= wr_gnt_n;
      wr_ptr   <= wr_ptr_n;
      aw_done  <= aw_done_n;
      w_done   <= w_done_n;
      rd_state <= rd_state_n;
      rd_gnt   <= rd_gnt_n;
      rd_ptr   <= rd_ptr_n;
    end
  end

  // AW/W request muxes, gated by phase so nothing leaks before the grant registers
  assign axi4_mst_awid    = wr_gnt ? axi4_s1_awid    : axi4_s0_awid;
  assign axi4_mst_awaddr  = wr_gnt ? axi4_s1_awaddr  : axi4_s0_awaddr;
  assign axi4_mst_awlen   = wr_gnt ? axi4_s1_awlen   : axi4_s0_awlen;
  assign axi4_mst_awsize  = wr_gnt ? axi4_s1_awsize  : axi4_s0_awsize;
  assign axi4_mst_awburst = wr_gnt ? axi4_s1_awburst : axi4_s0_awburst;
  assign axi4_mst_awqos   = 4'd0;
  assign axi4_mst_awvalid = wr_xfer & ~aw_done & (wr_gnt ? axi4_s1_awvalid : axi4_s0_awvalid);
  assign axi4_s0_awready  = wr_xfer & ~aw_done & ~wr_gnt & axi4_mst_awready;
  assign axi4_s1_awready  = wr_xfer & ~aw_done &  wr_gnt & axi4_mst_awready;

  assign axi4_mst_wdata   = wr_gnt ? axi4_s1_wdata : axi4_s0_wdata;
  assign axi4_mst_wstrb   = wr_gnt ? axi4_s1_wstrb : axi4_s0_wstrb;
  assign axi4_mst_wlast   = wr_gnt ? axi4_s1_wlast : axi4_s0_wlast;
  assign axi4_mst_wvalid  = wr_xfer & ~w_done & (wr_gnt ? axi4_s1_wvalid : axi4_s0_wvalid);
  assign axi4_s0_wready   = wr_xfer & ~w_done & ~wr_gnt & axi4_mst_wready;
  assign axi4_s1_wready   = wr_xfer & ~w_done &  wr_gnt & axi4_mst_wready;

  // B response routing: payload broadcast, valid only to the granted master
  assign axi4_s0_bid      = axi4_mst_bid;
  assign axi4_s0_bresp    = axi4_mst_bresp;
  assign axi4_s1_bid      = axi4_mst_bid;
  assign axi4_s1_bresp    = axi4_mst_bresp;
  assign axi4_s0_bvalid   = wr_resp & ~wr_gnt & axi4_mst_bvalid;
  assign axi4_s1_bvalid   = wr_resp &  wr_gnt & axi4_mst_bvalid;
  assign axi4_mst_bready  = wr_resp & (wr_gnt ? axi4_s1_bready : axi4_s0_bready);

  // AR request mux
  assign axi4_mst_arid    = rd_gnt ? axi4_s1_arid    : axi4_s0_arid;
  assign axi4_mst_araddr  = rd_gnt ? axi4_s1_araddr  : axi4_s0_araddr;
  assign axi4_mst_arlen   = rd_gnt ? axi4_s1_arlen   : axi4_s0_arlen;
  assign axi4_mst_arsize  = rd_gnt ? axi4_s1_arsize  : axi4_s0_arsize;
  assign axi4_mst_arburst = rd_gnt ? axi4_s1_arburst : axi4_s0_arburst;
  assign axi4_mst_arqos   = 4'd0;
  assign axi4_mst_arvalid = rd_addr & (rd_gnt ? axi4_s1_arvalid : axi4_s0_arvalid);
  assign axi4_s0_arready  = rd_addr & ~rd_gnt & axi4_mst_arready;
  assign axi4_s1_arready  = rd_addr &  rd_gnt & axi4_mst_arready;

  // R data routing
  assign axi4_s0_rid      = axi4_mst_rid;
  assign axi4_s0_rdata    = axi4_mst_rdata;
  assign axi4_s0_rresp    = axi4_mst_rresp;
  assign axi4_s0_rlast    = axi4_mst_rlast;
  assign axi4_s1_rid      = axi4_mst_rid;
  assign axi4_s1_rdata    = axi4_mst_rdata;
  assign axi4_s1_rresp    = axi4_mst_rresp;
  assign axi4_s1_rlast    = axi4_mst_rlast;
  assign axi4_s0_rvalid   = rd_data & ~rd_gnt & axi4_mst_rvalid;
  assign axi4_s1_rvalid   = rd_data &  rd_gnt & axi4_mst_rvalid;
  assign axi4_mst_rready  = rd_data & (rd_gnt ? axi4_s1_rready : axi4_s0_rready);

endmodule
